kronos_data_responder: RTL and testbench

- Responder (slave) end of the Kronos core data-memory req/ack interface.
- Holds on-chip word RAM and a small MMIO page: 64-bit machine timer (mtime/mtimecmp), software-interrupt bit, LED register.
- Drives timer_interrupt and software_interrupt back to the core.
- Instantiated in the FPGA top level alongside the core; its data_* ports connect one-to-one to the core's data_* ports.

---
 rtl/kronos_data_responder.sv | 168 ++++++++++++++++
 tb/tb_kronos_data_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_data_responder.sv
// Data-side responder for the Kronos core: word RAM plus a 32-byte MMIO page
// holding the 64-bit machine timer, the software-interrupt bit and the LED register.
module kronos_data_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic        timer_interrupt,
  output logic        software_interrupt,
  output logic [9:0]  led_out
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Handshake: the core holds data_req high until data_ack; the request is
  // sampled only in IDLE, data_ack pulses for one cycle and read data is valid with it.
  typedef enum logic {ST_IDLE, ST_ACK} state_e;
  state_e state_q, state_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] rd_data_q, rd_data_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [9:0]  led_q, led_d;
  logic        irq_q;

  logic [29:0] word_addr;
  logic [29:0] ram_woff;
  logic [29:0] mmio_woff;
  logic        ram_hit;
  logic        mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [2:0]  mmio_sel;
  logic        access;
  logic        wr_ram;
  logic        wr_mmio;
  logic        tick;
  logic [31:0] rd_val;
  logic [31:0] mmio_new;
  logic        unused_ok;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign word_addr = data_addr[31:2];
  assign ram_woff  = word_addr - MEM_BASE[31:2];
  assign mmio_woff = word_addr - MMIO_BASE[31:2];
  assign ram_hit   = (word_addr >= MEM_BASE[31:2]) && (ram_woff < 30'(MEM_WORDS));
  assign mmio_hit  = (word_addr >= MMIO_BASE[31:2]) && (mmio_woff < 30'd8);
  assign ram_idx   = ram_woff[AW-1:0];
  assign mmio_sel  = mmio_woff[2:0];
  assign unused_ok = ^{data_addr[1:0], ram_woff[29:AW], mmio_woff[29:3]};

  assign access  = (state_q == ST_IDLE) && data_req;
  assign wr_ram  = access && data_wr_en && ram_hit;
  assign wr_mmio = access && data_wr_en && mmio_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (data_req) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The MMIO read value doubles as the "old" word for byte-masked MMIO writes.
  always_comb begin
    rd_val = 32'h0;
    if (ram_hit) begin
      rd_val = mem_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_sel)
        3'd0:    rd_val = mtime_q[31:0];
        3'd1:    rd_val = mtime_q[63:32];
        3'd2:    rd_val = mtimecmp_q[31:0];
        3'd3:    rd_val = mtimecmp_q[63:32];
        3'd4:    rd_val = {31'h0, msip_q};
        3'd5:    rd_val = {22'h0, led_q};
        default: rd_val = 32'h0;
      endcase
    end
  end

  assign mmio_new  = merge(rd_val, data_wr_data, data_mask);
  assign rd_data_d = (access && !data_wr_en) ? rd_val : rd_data_q;

  // A software write to either mtime half replaces the increment for that cycle.
  always_comb begin
    tick       = (presc_q == PW'(TICK_DIV - 1));
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    led_d      = led_q;
    if (wr_mmio) begin
      case (mmio_sel)
        3'd0:    mtime_d    = {mtime_q[63:32], mmio_new};
        3'd1:    mtime_d    = {mmio_new, mtime_q[31:0]};
        3'd2:    mtimecmp_d = {mtimecmp_q[63:32], mmio_new};
        3'd3:    mtimecmp_d = {mmio_new, mtimecmp_q[31:0]};
        3'd4:    msip_d     = mmio_new[0];
        3'd5:    led_d      = mmio_new[9:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_data_q  <= 32'h0;
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      led_q      <= 10'h0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      led_q      <= led_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (data_mask[i]) mem_q[ram_idx][8*i +: 8] <= data_wr_data[8*i +: 8];
      end
    end
  end

  assign data_ack           = (state_q == ST_ACK);
  assign data_rd_data       = rd_data_q;
  assign timer_interrupt    = irq_q;
  assign software_interrupt = msip_q;
  assign led_out            = led_q;

endmodule

// File: tb/tb_kronos_data_responder.sv
// Randomized scoreboard bench for kronos_data_responder against an address-map
// and timer model built from plain arithmetic.
module tb_kronos_data_responder;

  localparam int W = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rd_data;
  logic        timer_interrupt;
  logic        software_interrupt;
  logic [9:0]  led_out;

  always #5 clk = ~clk;

  kronos_data_responder dut (
    .clk                (clk),
    .rst                (rst),
    .data_addr          (data_addr),
    .data_wr_data       (data_wr_data),
    .data_mask          (data_mask),
    .data_wr_en         (data_wr_en),
    .data_req           (data_req),
    .data_ack           (data_ack),
    .data_rd_data       (data_rd_data),
    .timer_interrupt    (timer_interrupt),
    .software_interrupt (software_interrupt),
    .led_out            (led_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mtime is mt_base at edge mt_stamp and advances one per edge.
  logic [31:0] ram_m [int];
  logic [63:0] cyc;
  logic [63:0] mt_base, mt_stamp, cmp_m;
  logic        msip_m;
  logic [9:0]  led_m;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 64'd0;
    else     cyc <= cyc + 64'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    mt_base  = 64'd0;
    mt_stamp = 64'd0;
    cmp_m    = 64'hFFFF_FFFF_FFFF_FFFF;
    msip_m   = 1'b0;
    led_m    = 10'd0;
  endtask

  // e is the edge at which the access happens; registers read their pre-edge value.
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [63:0] e);
    logic [31:0] wa;
    logic [63:0] mt;
    wa = a & 32'hFFFF_FFFC;
    mt = mt_base + e - 64'd1 - mt_stamp;
    if (wa < 32'd4096) return ram_m.exists(wa) ? ram_m[wa] : 32'h0;
    if (wa >= 32'h8000_0000 && wa < 32'h8000_0020) begin
      case (wa - 32'h8000_0000)
        32'h00: return mt[31:0];
        32'h04: return mt[63:32];
        32'h08: return cmp_m[31:0];
        32'h0C: return cmp_m[63:32];
        32'h10: return {31'h0, msip_m};
        32'h14: return {22'h0, led_m};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                             input logic [63:0] e);
    logic [31:0] wa;
    logic [31:0] nw;
    logic [63:0] mt;
    wa = a & 32'hFFFF_FFFC;
    mt = mt_base + e - 64'd1 - mt_stamp;
    if (wa < 32'd4096) begin
      ram_m[wa] = bmerge(ram_m.exists(wa) ? ram_m[wa] : 32'h0, d, m);
    end else if (wa >= 32'h8000_0000 && wa < 32'h8000_0020) begin
      nw = bmerge(model_read(a, e), d, m);
      case (wa - 32'h8000_0000)
        32'h00: begin mt_base = {mt[63:32], nw}; mt_stamp = e; end
        32'h04: begin mt_base = {nw, mt[31:0]};  mt_stamp = e; end
        32'h08: cmp_m = {cmp_m[63:32], nw};
        32'h0C: cmp_m = {nw, cmp_m[31:0]};
        32'h10: msip_m = nw[0];
        32'h14: led_m = nw[9:0];
        default: ;
      endcase
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic we);
    int n;
    @(negedge clk);
    while (data_ack) @(negedge clk);
    data_addr = a; data_wr_data = d; data_mask = m; data_wr_en = we; data_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!data_ack && n < 10);
    if (!data_ack) begin
      check("ack_timeout", data_ack, 1);
      data_req = 1'b0;
      return;
    end
    check("ack_latency", n, 1);
    if (we) begin
      model_write(a, d, m, cyc);
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b1, model_read(a, cyc)});
    end
    data_req = 1'b0;
    data_addr = $urandom(); data_wr_data = $urandom();
    data_mask = 4'($urandom()); data_wr_en = 1'($urandom());
  endtask

  task automatic reset_during_ack(input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge clk);
    while (data_ack) @(negedge clk);
    data_addr = a; data_wr_data = d; data_mask = 4'hF; data_wr_en = we; data_req = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_ack", data_ack, 1);
    if (we) model_write(a, d, 4'hF, cyc);
    rst = 1'b1;
    model_reset();
    data_req = 1'b0;
    #1;
    check("reset_drops_ack", data_ack, 0);
    check("reset_rd_data", data_rd_data, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  logic prev_ack;
  logic [63:0] prev_mt, prev_cmp;
  logic [W-1:0] item;

  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
      prev_mt  = 64'd0;
      prev_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_q.delete();
    end else begin
      check("timer_irq", timer_interrupt, prev_mt >= prev_cmp);
      check("sw_irq", software_interrupt, msip_m);
      check("led", led_out, led_m);
      if (data_ack) begin
        check("ack_width", prev_ack, 0);
        if (exp_q.size() == 0) begin
          check("ack_unexpected", data_ack, 0);
        end else begin
          item = exp_q.pop_front();
          if (item[32]) check("rd_data", data_rd_data, item[31:0]);
        end
      end
      prev_ack = data_ack;
      prev_mt  = mt_base + cyc - mt_stamp;
      prev_cmp = cmp_m;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] a;
    rst = 1'b1; data_req = 1'b0; data_addr = 32'h0; data_wr_data = 32'h0;
    data_mask = 4'h0; data_wr_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", data_ack, 0);
    check("rst_rd_data", data_rd_data, 32'h0);
    check("rst_timer_irq", timer_interrupt, 0);
    check("rst_sw_irq", software_interrupt, 0);
    check("rst_led", led_out, 10'h0);
    #1 rst = 1'b0;

    // basic RAM write/read and byte masking
    txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    txn(32'h0000_0010, 32'h0, 4'h0, 1'b0);
    txn(32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1);
    txn(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b1);
    txn(32'h0000_0022, 32'h0, 4'h0, 1'b0);
    txn(32'h0000_0000, 32'h1234_5678, 4'hF, 1'b1);

    // msip and LED
    txn(32'h8000_0010, 32'h1, 4'hF, 1'b1);
    txn(32'h8000_0014, 32'h3FF, 4'hF, 1'b1);
    txn(32'h8000_0014, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0014, 32'h0, 4'b0010, 1'b1);
    txn(32'h8000_0010, 32'h0, 4'h0, 1'b0);

    // timer compare at 100
    txn(32'h8000_0000, 32'h0, 4'hF, 1'b1);
    txn(32'h8000_0004, 32'h0, 4'hF, 1'b1);
    txn(32'h8000_000C, 32'h0, 4'hF, 1'b1);
    txn(32'h8000_0008, 32'd100, 4'hF, 1'b1);
    k = 0;
    while (!timer_interrupt && k < 300) begin @(negedge clk); k++; end
    check("irq_rise_seen", timer_interrupt, 1);
    txn(32'h8000_0008, 32'hFFFF_FFFF, 4'hF, 1'b1);
    repeat (2) @(negedge clk);
    check("irq_fall", timer_interrupt, 0);

    // 64-bit wrap and partial mtime write
    txn(32'h8000_000C, 32'hFFFF_FFFF, 4'hF, 1'b1);
    txn(32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 1'b1);
    txn(32'h8000_0000, 32'hFFFF_FFF0, 4'hF, 1'b1);
    repeat (30) @(negedge clk);
    txn(32'h8000_0004, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0000, 32'h0000_00AA, 4'b0001, 1'b1);
    txn(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0008, 32'h0, 4'h0, 1'b0);

    // unmapped and reserved MMIO
    txn(32'h4000_0000, 32'h0, 4'h0, 1'b0);
    txn(32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    txn(32'h0000_0000, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0018, 32'h5555_5555, 4'hF, 1'b1);
    txn(32'h8000_0018, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_001C, 32'h0, 4'h0, 1'b0);
    txn(32'h0000_1000, 32'h0, 4'h0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 8; i++) txn(32'h100 + 32'(4*i), $urandom(), 4'hF, 1'b1);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 99);
      if (k < 70)      a = 32'h100 + 32'($urandom_range(0, 31));
      else if (k < 85) a = 32'h1000 + $urandom_range(0, 32'h7FFF_EFFF);
      else             a = 32'h8000_0010 + 32'($urandom_range(0, 15));
      txn(a, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // reset during ack of a read, then of a write
    reset_during_ack(32'h0000_0010, 32'h0, 1'b0);
    txn(32'h8000_0008, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_000C, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    txn(32'h0000_0010, 32'h0, 4'h0, 1'b0);
    reset_during_ack(32'h0000_0030, 32'hCAFE_F00D, 1'b1);
    txn(32'h0000_0030, 32'h0, 4'h0, 1'b0);
    txn(32'h8000_0014, 32'h0, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
